// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and stream
// framing constants.
package program_loader_pkg;

    // Payload bytes that make up one 32-bit instruction word.
    localparam int BYTES_PER_WORD = 4;

    // Width of the header byte that carries the word count.
    localparam int HDR_W = 8;

    // Loader FSM states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/program_loader_byte_packer.sv
// Little-endian byte packer: collects BYTES_PER_WORD stream bytes into one
// instruction word. The first byte of a word lands in bits 7:0.
module byte_packer
    import program_loader_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_accept,
    input  logic [7:0]                  i_byte,
    input  logic                        i_clear,
    output logic [8*BYTES_PER_WORD-1:0] o_word,
    output logic                        o_word_full
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

    logic [CNT_W-1:0]            r_cnt;
    logic [8*BYTES_PER_WORD-1:0] r_word;

    // Insert each accepted byte at its lane; the counter wraps back to lane 0
    // after the last byte so the next word starts cleanly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_clear) begin
            r_cnt  <= '0;
        end else if (i_accept) begin
            r_word[{r_cnt, 3'b000} +: 8] <= i_byte;
            r_cnt                        <= r_cnt + 1'b1;
        end
    end

    assign o_word      = r_word;
    // Pulses on the edge that accepts the final byte of a word.
    assign o_word_full = i_accept && (r_cnt == LAST_BYTE);

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader: takes a header byte N followed by 4*N
// little-endian payload bytes, writes N words into instruction memory and
// then releases the core from reset. A bad header latches an error that only
// the loader reset clears.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int MEM_WORDS  = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_error,
    output logic [7:0]            words_loaded
);

    localparam logic [HDR_W-1:0] MAX_N = HDR_W'(MEM_WORDS);

    state_t     r_state;
    logic [7:0] r_n;
    logic [7:0] r_count;

    logic        w_hdr_slot;
    logic        w_hdr_accept;
    logic        w_hdr_ok;
    logic        w_pack_accept;
    logic        w_word_full;
    logic [31:0] w_word;
    logic [7:0]  w_next_count;

    // The header is taken from IDLE, or from DONE to start a reload.
    assign w_hdr_slot    = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_hdr_accept  = in_valid && w_hdr_slot;
    assign w_hdr_ok      = (in_data != 8'd0) && (in_data <= MAX_N);
    assign w_pack_accept = in_valid && (r_state == ST_LOAD);
    assign w_next_count  = r_count + 8'd1;

    byte_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .i_accept    (w_pack_accept),
        .i_byte      (in_data),
        .i_clear     (w_hdr_accept),
        .o_word      (w_word),
        .o_word_full (w_word_full)
    );

    // Loader FSM: header check, byte collection, one-cycle write, release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_n     <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_hdr_accept) begin
                        if (w_hdr_ok) begin
                            r_n     <= in_data;
                            r_count <= '0;
                            r_state <= ST_LOAD;
                        end else begin
                            r_state <= ST_ERR;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_word_full) begin
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    r_count <= w_next_count;
                    r_state <= (w_next_count == r_n) ? ST_DONE : ST_LOAD;
                end
                ST_ERR: begin
                    r_state <= ST_ERR;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Every output decodes from registered state only; the write address and
    // data are the index and packer registers presented during WRITE.
    assign in_ready     = (r_state == ST_IDLE) || (r_state == ST_LOAD) ||
                          (r_state == ST_DONE);
    assign mem_we       = (r_state == ST_WRITE);
    assign mem_addr     = r_count[ADDR_WIDTH-1:0];
    assign mem_wdata    = w_word;
    assign cpu_reset    = (r_state != ST_DONE);
    assign load_done    = (r_state == ST_DONE);
    assign load_error   = (r_state == ST_ERR);
    assign words_loaded = r_count;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a stream-level model predicts the
// handshake, write strobes and status outputs every cycle, and directed
// scenarios pin the model with hand-computed values.
module tb_program_loader;

    localparam int MW = 32;
    localparam int AW = 5;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data  = 8'h00;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_reset;
    logic          load_done;
    logic          load_error;
    logic [7:0]    words_loaded;

    always #5 clk = ~clk;

    program_loader #(.MEM_WORDS(MW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_reset    (cpu_reset),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- stream-level model ----------------
    bit          m_err   = 0;
    bit          m_done  = 0;
    bit          m_wpend = 0;
    int          m_cnt   = 0;
    int          m_n     = 0;
    int          m_left  = 0;
    int          m_nb    = 0;
    logic [31:0] m_word  = 32'h0;

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_err = 0; m_done = 0; m_wpend = 0;
                m_cnt = 0; m_n = 0; m_left = 0; m_nb = 0;
            end else if (m_wpend) begin
                m_wpend = 0;
                m_cnt++;
                if (m_cnt == m_n) m_done = 1;
            end else if (in_valid && !m_err) begin
                if (m_left == 0) begin
                    m_done = 0;
                    if (in_data >= 1 && in_data <= MW) begin
                        m_n = in_data; m_cnt = 0; m_left = 4 * in_data; m_nb = 0;
                    end else begin
                        m_err = 1;
                    end
                end else begin
                    m_word[8*m_nb +: 8] = in_data;
                    m_nb++;
                    m_left--;
                    if (m_nb == 4) begin
                        m_nb = 0;
                        m_wpend = 1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare + write scoreboard ----------------
    logic [31:0] bmem [0:MW-1];
    int          we_count  = 0;
    int          cyc       = 0;
    int          last_we   = -1;
    int          rel_cyc   = -1;
    int          last_addr = -1;
    logic        prev_we   = 1'b0;
    logic        prev_crst = 1'b1;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                chk("in_ready",     32'(in_ready),     32'(!m_err && !m_wpend));
                chk("cpu_reset",    32'(cpu_reset),    32'(!m_done));
                chk("load_done",    32'(load_done),    32'(m_done));
                chk("load_error",   32'(load_error),   32'(m_err));
                chk("words_loaded", 32'(words_loaded), 32'(m_cnt[7:0]));
                chk("mem_we",       32'(mem_we),       32'(m_wpend));
                if (m_wpend) begin
                    chk("mem_addr",  32'(mem_addr), 32'(m_cnt[AW-1:0]));
                    chk("mem_wdata", mem_wdata,     m_word);
                end
                if (prev_we) chk("we_back_to_back", 32'(mem_we), 32'h0);
                if (mem_we) begin
                    bmem[mem_addr] = mem_wdata;
                    we_count++;
                    last_we   = cyc;
                    last_addr = int'(mem_addr);
                end
                if (prev_crst && !cpu_reset) rel_cyc = cyc;
                prev_we   = mem_we;
                prev_crst = cpu_reset;
            end else begin
                prev_we   = 1'b0;
                prev_crst = 1'b1;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input logic [7:0] b);
        int g = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("send_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 0; i < 4; i++) begin
            send(w[8*i +: 8]);
            if (gap) @(negedge clk);
        end
    endtask

    task automatic wait_done();
        int g = 0;
        while (!load_done && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("wait_done", 32'(load_done), 32'h1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"},     32'(in_ready),     32'h1);
        chk({tag, "_mem_we"},       32'(mem_we),       32'h0);
        chk({tag, "_mem_addr"},     32'(mem_addr),     32'h0);
        chk({tag, "_mem_wdata"},    mem_wdata,         32'h0);
        chk({tag, "_cpu_reset"},    32'(cpu_reset),    32'h1);
        chk({tag, "_load_done"},    32'(load_done),    32'h0);
        chk({tag, "_load_error"},   32'(load_error),   32'h0);
        chk({tag, "_words_loaded"}, 32'(words_loaded), 32'h0);
    endtask

    // Assert reset away from the clock edge and check the asynchronous effect.
    task automatic do_reset(input string tag);
        #2 reset = 1'b0;
        #1 check_reset_values(tag);
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [31:0] img(input int i);
        logic [7:0] a;
        a = 8'(i);
        return {a, ~a, 8'(i * 3), 8'h13};
    endfunction

    // ---------------- directed scenarios ----------------
    initial begin
        int we_base;
        for (int i = 0; i < MW; i++) bmem[i] = 32'h0;

        @(negedge clk);
        check_reset_values("rst0");
        #1 reset = 1'b1;
        @(negedge clk);

        // Two-word image, in_valid held high.
        send(8'h02);
        send_word(32'h0000_0013, 1'b0);
        send_word(32'h0010_0093, 1'b0);
        wait_done();
        chk("t1_mem0",      bmem[0],           32'h0000_0013);
        chk("t1_mem1",      bmem[1],           32'h0010_0093);
        chk("t1_words",     32'(words_loaded), 32'd2);
        chk("t1_we_count",  32'(we_count),     32'd2);
        chk("t1_cpu_reset", 32'(cpu_reset),    32'h0);
        chk("t1_release",   32'(rel_cyc),      32'(last_we + 1));

        // Reload from DONE with a one-word image.
        we_base = we_count;
        send(8'h01);
        chk("t2_crst_on_hdr", 32'(cpu_reset), 32'h1);
        chk("t2_done_clear",  32'(load_done), 32'h0);
        send_word(32'hCAFE_F00D, 1'b0);
        wait_done();
        chk("t2_mem0",  bmem[0],                   32'hCAFE_F00D);
        chk("t2_addr",  32'(last_addr),            32'd0);
        chk("t2_we",    32'(we_count - we_base),   32'd1);
        chk("t2_words", 32'(words_loaded),         32'd1);

        // Same two-word image with in_valid toggling every cycle.
        do_reset("rst1");
        bmem[0] = 32'h0; bmem[1] = 32'h0;
        we_base = we_count;
        send(8'h02);
        @(negedge clk);
        send_word(32'h0000_0013, 1'b1);
        send_word(32'h0010_0093, 1'b1);
        wait_done();
        chk("t3_mem0",  bmem[0],                 32'h0000_0013);
        chk("t3_mem1",  bmem[1],                 32'h0010_0093);
        chk("t3_we",    32'(we_count - we_base), 32'd2);
        chk("t3_words", 32'(words_loaded),       32'd2);

        // Header 0 and header MEM_WORDS+1 both latch the error.
        for (int k = 0; k < 2; k++) begin
            do_reset("rst_err");
            we_base = we_count;
            send((k == 0) ? 8'h00 : 8'(MW + 1));
            chk("err_flag_next",  32'(load_error), 32'h1);
            repeat (5) @(negedge clk);
            chk("err_flag_hold",  32'(load_error), 32'h1);
            chk("err_ready_low",  32'(in_ready),   32'h0);
            chk("err_cpu_reset",  32'(cpu_reset),  32'h1);
            chk("err_no_write",   32'(we_count - we_base), 32'd0);
        end

        // Abort after 6 payload bytes, then a clean one-word load.
        do_reset("rst2");
        send(8'h02);
        send_word(32'h1122_3344, 1'b0);
        send(8'h55);
        send(8'h66);
        do_reset("abort");
        bmem[0] = 32'h0;
        we_base = we_count;
        send(8'h01);
        send_word(32'hA5A5_5A5A, 1'b0);
        wait_done();
        chk("t5_mem0", bmem[0],                 32'hA5A5_5A5A);
        chk("t5_addr", 32'(last_addr),          32'd0);
        chk("t5_we",   32'(we_count - we_base), 32'd1);

        // Full-depth image, then the core runs with no further writes.
        do_reset("rst3");
        for (int i = 0; i < MW; i++) bmem[i] = 32'h0;
        we_base = we_count;
        send(8'(MW));
        for (int i = 0; i < MW; i++) begin
            chk("full_cpu_held", 32'(cpu_reset), 32'h1);
            send_word(img(i), 1'b0);
        end
        wait_done();
        for (int i = 0; i < MW; i++) chk("full_mem", bmem[i], img(i));
        chk("full_words", 32'(words_loaded), 32'(MW));
        we_base = we_count;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk("run_cpu_released", 32'(cpu_reset), 32'h0);
        end
        chk("run_no_write", 32'(we_count - we_base), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream loader that fills the CPU's instruction memory and then releases the core from reset. It sits between a host-side byte source (UART receiver, debug bridge or bench driver) and the program-memory write port of `multiple_instructions`. It writes the memory that the core later fetches from, so a program loads in-system instead of by file preload. It holds `cpu_reset` high until a complete, well-formed image has been written.

## Interface
Parameters:
- `MEM_WORDS`, 32: instruction-memory depth in 32-bit words; legal range 1..255.
- `ADDR_WIDTH`, 5: word-address width; must satisfy 2^ADDR_WIDTH >= MEM_WORDS.

Ports:
- `clk` in, 1: single clock; all logic is rising-edge.
- `reset` in, 1: asynchronous, active-low reset.
- `in_valid` in, 1: byte on `in_data` is valid.
- `in_data` in, 8: stream byte.
- `in_ready` out, 1: loader accepts the byte this cycle.
- `mem_we` out, 1: one-cycle write strobe to program memory.
- `mem_addr` out, ADDR_WIDTH: word address of the write.
- `mem_wdata` out, 32: instruction word.
- `cpu_reset` out, 1: active-high reset to the core.
- `load_done` out, 1: image complete; core running.
- `load_error` out, 1: bad header; sticky until `reset`.
- `words_loaded` out, 8: count of words written in the current load.

## Operation
- A byte transfers on a rising edge where `in_valid && in_ready`.
- Stream format: one header byte N (word count), then 4·N payload bytes, little-endian per word. The first byte maps to bits 7:0.
- States:
  - IDLE: the next accepted byte is the header. If 1 <= N <= MEM_WORDS, latch N, clear the word index and `words_loaded`, and go to LOAD. Otherwise go to ERR.
  - LOAD: accept bytes into the packer. On the 4th byte of a word, go to WRITE.
  - WRITE: `mem_we`=1 for exactly one cycle with `mem_addr`=index and `mem_wdata`=packed word. Then increment index and `words_loaded`. If the new count equals N, go to DONE; otherwise go to LOAD.
  - DONE: `cpu_reset`=0 and `load_done`=1. An accepted byte is treated as a new header. Evaluation is as in IDLE, but `cpu_reset` reasserts and `load_done` clears in the same edge.
  - ERR: `in_ready`=0, `cpu_reset`=1, `load_error`=1. Left only by `reset`.
- `in_ready`=1 in IDLE, LOAD and DONE; 0 in WRITE and ERR.
- `cpu_reset`=1 in every state except DONE.
- Index arithmetic is 8-bit. `mem_addr` takes the low ADDR_WIDTH bits. The header check guarantees there is no wrap.
- `in_valid` low mid-word: the packer holds its partial bytes indefinitely; there is no timeout.

## Timing
- Reset values: state IDLE, `in_ready` 1, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `cpu_reset` 1, `load_done` 0, `load_error` 0, `words_loaded` 0.
- All outputs are registered or decoded from registered state only. There is no combinational path from `in_valid`/`in_data`.
- Per-word latency:
  - `mem_we` rises the cycle after the 4th byte is accepted.
  - The minimum word period is 5 cycles: 4 accept cycles plus 1 write cycle.
- Release latency:
  - `cpu_reset` falls and `load_done` rises in the cycle after the last WRITE.
  - The core's first fetch therefore sees a fully written memory.
- `reset` asserted mid-load aborts immediately:
  - Outputs go to their reset values asynchronously.
  - Partially written memory is not cleared.
  - `cpu_reset` stays 1.
- `mem_we` is never high in two consecutive cycles.

## Structure
- Package `program_loader_pkg` holds:
  - the state enum (IDLE, LOAD, WRITE, DONE, ERR);
  - `BYTES_PER_WORD`=4;
  - header-width constant 8.
- Sub-module `byte_packer`:
  - 2-bit byte counter and 32-bit little-endian shift/insert register;
  - inputs: `accept`, byte, clear;
  - outputs: `word`, `word_full`.
- Top level holds the FSM, the N and index registers, and the output registers.

## Test plan
- Header 0x02, then bytes 13 00 00 00, 93 00 10 00 with `in_valid` held high:
  - `mem_we` pulses at addr 0 with data 0x00000013, then at addr 1 with data 0x00100093;
  - `cpu_reset` falls 1 cycle after the second write;
  - `words_loaded`=2.
- Same image with `in_valid` toggled 1-0-1 every cycle:
  - identical writes;
  - no byte lost or duplicated;
  - `in_ready` is 0 only in the WRITE cycles.
- Header 0x00, and separately header MEM_WORDS+1:
  - `load_error`=1 next cycle;
  - `in_ready`=0 and `cpu_reset`=1 thereafter;
  - no `mem_we`.
- `reset` low after 6 payload bytes:
  - outputs return to reset values asynchronously;
  - a fresh load of 1 word then completes normally at addr 0.
- In DONE, send header 0x01 plus 4 bytes:
  - `cpu_reset` reasserts on the header edge;
  - one write at addr 0;
  - release again.
- Full load of MEM_WORDS words with driving the core:
  - x31 must read 0 on every clock for 32 cycles after `cpu_reset` falls.
